pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central pipeline sequencing controller for the 5-stage MIPS core. It consumes the decoded control signals from the instruction decoder (`read_mode`, `write_mode`, `chip_select`, `PCSrc`) together with register indices. It drives the enable and flush inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It handles the post-reset pipeline drain, load-use stalls, taken-jump redirects and a handshaked multi-cycle data memory, and detects memory timeouts.

## Interface
- `INIT_CYCLES`, 4: bubble-insertion cycles after reset; must be ≥1.
- `MEM_TIMEOUT`, 16: consecutive not-ready memory cycles before a fatal error; must be ≥2.
- `STALL_CNT_W`, 16: width of the stall statistics counter.

- `clk` in 1: single clock; all state is on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `id_rs`, `id_rt` in 5: source registers of the instruction in ID.
- `id_uses_rs`, `id_uses_rt` in 1: the ID instruction actually reads rs / rt.
- `ex_read_mode` in 1: the instruction in EX is a load.
- `ex_rd` in 5: destination register of the instruction in EX.
- `ex_redirect` in 1: taken jump/branch resolved in EX (`PCSrc`).
- `mem_chip_select` in 1: the instruction in MEM accesses data memory.
- `mem_ready` in 1: data memory completes the access this cycle.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en` out 1: register load enables.
- `ifid_flush`, `idex_flush`, `exmem_flush`, `memwb_flush` out 1: load a bubble. Flush overrides en.
- `busy` out 1: state ≠ RUN.
- `mem_timeout` out 1: sticky fatal flag.
- `stall_cycles` out `STALL_CNT_W`: saturating count of cycles with `pc_en`=0 in RUN/MEM_WAIT.

## Operation
- States: INIT, RUN, MEM_WAIT, ERROR. Outputs are combinational from state and current inputs. State and counters are registered.
- Definition of load_use: `ex_read_mode` & (`ex_rd`≠0) & ((`id_uses_rs` & `id_rs`==`ex_rd`) | (`id_uses_rt` & `id_rt`==`ex_rd`)).
- Definition of mem_stall: `mem_chip_select` & !`mem_ready`.
- **INIT**
  - `pc_en`=0, all enables 0, all flushes 1.
  - Leaves for RUN after `INIT_CYCLES` cycles with `rst_n`=1.
  - All inputs are ignored.
- **RUN**, in priority order:
  1. mem_stall:
     - `pc_en`, `ifid_en`, `idex_en`, `exmem_en` = 0.
     - `memwb_flush`=1.
     - Load wait_cnt=1, go to MEM_WAIT.
     - If `MEM_TIMEOUT` is reached instead, see MEM_WAIT.
  2. `ex_redirect`:
     - `pc_en`=1, `ifid_flush`=`idex_flush`=1.
     - Other enables 1.
     - load_use is ignored because the ID instruction is squashed.
  3. load_use:
     - `pc_en`=`ifid_en`=0, `idex_flush`=1.
     - `exmem_en`=`memwb_en`=1.
  4. Otherwise: all enables 1, no flushes.
- **MEM_WAIT**
  - If `mem_ready`=1: apply RUN rules 2–4 this cycle and go to RUN.
  - Otherwise: hold the freeze pattern of rule 1 and increment wait_cnt.
  - When the `MEM_TIMEOUT`-th consecutive not-ready cycle ends (the RUN entry cycle counts as 1), go to ERROR.
- **ERROR**
  - All enables 0, all flushes 0, `mem_timeout`=1.
  - Exits only through reset.
- `busy` = 1 in INIT, MEM_WAIT and ERROR.
- `stall_cycles`:
  - Increments on every RUN/MEM_WAIT cycle with `pc_en`=0.
  - Saturates at all-ones. No wrap.
  - Cleared only by reset.
- `ex_redirect` arriving during MEM_WAIT persists, because EX is frozen, and is honoured on the release cycle.
- Register $0 never causes a stall.

## Timing
- Reset (`rst_n`=0 at an edge):
  - Next state is INIT, init_cnt=0, wait_cnt=0, `stall_cycles`=0.
  - `mem_timeout` is cleared.
  - Outputs during and after reset follow INIT: `pc_en`=0, enables 0, flushes 1, `busy`=1, `mem_timeout`=0.
- Reset asserted in any state, including ERROR or MEM_WAIT, aborts immediately to INIT on the next edge.
- Load-use costs exactly 1 cycle. The next cycle re-evaluates, and the load has moved to MEM, so there is no repeat stall.
- Redirect costs 2 bubbles (IF/ID and ID/EX), with zero stall cycles counted.
- Memory access with N not-ready cycles, N < `MEM_TIMEOUT`: N freeze cycles, then release on the `mem_ready` cycle.
- Zero-latency access (`mem_ready`=1 in the same cycle): no freeze.

## Structure
- Package `pipe_ctrl_pkg`: state enum (INIT, RUN, MEM_WAIT, ERROR) and `REG_ZERO` = 5'd0.
- Sub-module `load_use_detect`: the combinational load_use comparison above. It is reused by the forwarding unit.
- The top module holds the FSM, init_cnt, wait_cnt, the stall counter and the output decode.

## Test plan
- **Reset:** `rst_n`=0 for 3 cycles, then 1.
  - 4 cycles of `pc_en`=0, all flushes 1, `busy`=1.
  - 5th cycle: RUN, all enables 1, `busy`=0.
- **Load-use:** `ex_read_mode`=1, `ex_rd`=8, `id_rs`=8, `id_uses_rs`=1.
  - One cycle of `pc_en`=`ifid_en`=0, `idex_flush`=1.
  - `stall_cycles` 0→1.
  - Repeat with `ex_rd`=0: no stall.
- **Redirect plus load-use in the same cycle:**
  - `pc_en`=1, `ifid_flush`=`idex_flush`=1.
  - `stall_cycles` unchanged.
- **Memory wait:** `mem_chip_select`=1, `mem_ready` low for 3 cycles, high on the 4th.
  - 3 freeze cycles with `memwb_flush`=1.
  - Release on the 4th cycle, `stall_cycles` +3.
  - `ex_redirect` held during the wait is honoured on the release cycle.
- **Timeout:** `mem_ready` held 0.
  - After 16 cycles: ERROR, `mem_timeout`=1, all enables 0.
  - State holds for 50 further cycles.
  - `rst_n`=0 returns to INIT with `mem_timeout`=0.
- **Saturation:** `STALL_CNT_W`=4, 20 load-use stalls.
  - `stall_cycles` ends at 15, with no wrap.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller.
// Control bundles and the common issue pattern live here.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT,
    RUN,
    MEM_WAIT,
    ERROR
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_INIT   = 9'b0_0000_1111;
  localparam ctrl_t CTRL_HALT   = 9'b0_0000_0000;
  localparam ctrl_t CTRL_FREEZE = 9'b0_0000_0001;
  localparam ctrl_t CTRL_GO     = 9'b1_1111_0000;

  // A squashed ID instruction cannot cause a load-use stall.
  function automatic ctrl_t issue_ctrl(
    input logic redirect,
    input logic load_use
  );
    ctrl_t c;
    c = CTRL_GO;
    if (redirect) begin
      c.ifid_flush = 1'b1;
      c.idex_flush = 1'b1;
    end else if (load_use) begin
      c.pc_en      = 1'b0;
      c.ifid_en    = 1'b0;
      c.idex_flush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use hazard comparator between the ID and EX stages.
// Shared with the forwarding unit.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_read_mode,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  output logic       load_use
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_uses_rs & (id_rs == ex_rd);
  assign rt_hit = id_uses_rt & (id_rt == ex_rd);

  assign load_use = ex_read_mode
                  & (ex_rd != REG_ZERO)
                  & (rs_hit | rt_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: init drain, load-use,
// redirect and handshaked data-memory freeze with timeout.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int INIT_CYCLES = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic                   id_uses_rs,
  input  logic                   id_uses_rt,
  input  logic                   ex_read_mode,
  input  logic [4:0]             ex_rd,
  input  logic                   ex_redirect,
  input  logic                   mem_chip_select,
  input  logic                   mem_ready,
  output logic                   pc_en,
  output logic                   ifid_en,
  output logic                   idex_en,
  output logic                   exmem_en,
  output logic                   memwb_en,
  output logic                   ifid_flush,
  output logic                   idex_flush,
  output logic                   exmem_flush,
  output logic                   memwb_flush,
  output logic                   busy,
  output logic                   mem_timeout,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam int IW = $clog2(INIT_CYCLES + 1);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  state_t          state;
  state_t          state_n;
  state_t          cur;
  logic [IW-1:0]   init_cnt;
  logic [IW-1:0]   init_cnt_n;
  logic [WW-1:0]   wait_cnt;
  logic [WW-1:0]   wait_cnt_n;
  logic            load_use;
  logic            mem_stall;
  logic            stall_inc;
  ctrl_t           ctrl;

  load_use_detect u_lud (
    .ex_read_mode (ex_read_mode),
    .ex_rd        (ex_rd),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .load_use     (load_use)
  );

  assign mem_stall = mem_chip_select & ~mem_ready;

  // Reset is synchronous, but outputs show the INIT pattern while it is held.
  assign cur = rst_n ? state : INIT;

  always_comb begin
    state_n    = state;
    init_cnt_n = init_cnt;
    wait_cnt_n = wait_cnt;
    ctrl       = CTRL_HALT;
    unique case (cur)
      INIT: begin
        ctrl = CTRL_INIT;
        if (init_cnt == IW'(INIT_CYCLES - 1)) begin
          state_n    = RUN;
          init_cnt_n = '0;
        end else begin
          init_cnt_n = init_cnt + 1'b1;
        end
      end
      RUN: begin
        if (mem_stall) begin
          ctrl       = CTRL_FREEZE;
          state_n    = MEM_WAIT;
          wait_cnt_n = WW'(1);
        end else begin
          ctrl = issue_ctrl(ex_redirect, load_use);
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          ctrl       = issue_ctrl(ex_redirect, load_use);
          state_n    = RUN;
          wait_cnt_n = '0;
        end else begin
          ctrl = CTRL_FREEZE;
          if (wait_cnt == WW'(MEM_TIMEOUT - 1)) begin
            state_n = ERROR;
          end else begin
            wait_cnt_n = wait_cnt + 1'b1;
          end
        end
      end
      ERROR: ctrl = CTRL_HALT;
      default: ctrl = CTRL_HALT;
    endcase
  end

  assign stall_inc = ((cur == RUN) || (cur == MEM_WAIT))
                   & ~ctrl.pc_en
                   & (stall_cycles != '1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= INIT;
      init_cnt     <= '0;
      wait_cnt     <= '0;
      stall_cycles <= '0;
    end else begin
      state    <= state_n;
      init_cnt <= init_cnt_n;
      wait_cnt <= wait_cnt_n;
      if (stall_inc) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
    end
  end

  assign pc_en       = ctrl.pc_en;
  assign ifid_en     = ctrl.ifid_en;
  assign idex_en     = ctrl.idex_en;
  assign exmem_en    = ctrl.exmem_en;
  assign memwb_en    = ctrl.memwb_en;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_flush = ctrl.exmem_flush;
  assign memwb_flush = ctrl.memwb_flush;
  assign busy        = (cur != RUN);
  assign mem_timeout = (cur == ERROR);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and random checks of pipeline_hazard_ctrl against
// a cycle-level behavioural model of the sequencing rules.
module tb_pipeline_hazard_ctrl;

  localparam int INIT_CYCLES = 4;
  localparam int MEM_TIMEOUT = 16;
  localparam int STALL_CNT_W = 4;
  localparam int STALL_MAX   = (1 << STALL_CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic       ex_read_mode;
  logic [4:0] ex_rd;
  logic       ex_redirect;
  logic       mem_chip_select;
  logic       mem_ready;
  logic       pc_en;
  logic       ifid_en;
  logic       idex_en;
  logic       exmem_en;
  logic       memwb_en;
  logic       ifid_flush;
  logic       idex_flush;
  logic       exmem_flush;
  logic       memwb_flush;
  logic       busy;
  logic       mem_timeout;
  logic [STALL_CNT_W-1:0] stall_cycles;

  int total  = 0;
  int passed = 0;

  // Model: remaining drain cycles, consecutive not-ready count,
  // fatal flag and expected stall total.
  int init_left = INIT_CYCLES;
  int nr_count  = 0;
  bit dead      = 1'b0;
  int stalls    = 0;

  pipeline_hazard_ctrl #(
    .INIT_CYCLES (INIT_CYCLES),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .STALL_CNT_W (STALL_CNT_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .ex_read_mode    (ex_read_mode),
    .ex_rd           (ex_rd),
    .ex_redirect     (ex_redirect),
    .mem_chip_select (mem_chip_select),
    .mem_ready       (mem_ready),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .idex_en         (idex_en),
    .exmem_en        (exmem_en),
    .memwb_en        (memwb_en),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .exmem_flush     (exmem_flush),
    .memwb_flush     (memwb_flush),
    .busy            (busy),
    .mem_timeout     (mem_timeout),
    .stall_cycles    (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle();
    id_rs           = 5'd0;
    id_rt           = 5'd0;
    id_uses_rs      = 1'b0;
    id_uses_rt      = 1'b0;
    ex_read_mode    = 1'b0;
    ex_rd           = 5'd0;
    ex_redirect     = 1'b0;
    mem_chip_select = 1'b0;
    mem_ready       = 1'b0;
  endtask

  // Bit order: pc, ifid/idex/exmem/memwb enables, then the four flushes.
  task automatic cycle();
    logic [8:0] exp_c;
    logic [8:0] obs_c;
    logic [8:0] mask;
    logic       exp_busy;
    logic       exp_to;
    logic       lu;
    logic       not_ready;
    logic       waiting;
    int         inc;
    exp_c     = 9'b0_0000_1111;
    exp_busy  = 1'b1;
    exp_to    = 1'b0;
    not_ready = 1'b0;
    inc       = 0;
    lu = ex_read_mode && (ex_rd != 5'd0) &&
         ((id_uses_rs && id_rs == ex_rd) ||
          (id_uses_rt && id_rt == ex_rd));
    if (!rst_n) begin
      exp_c = 9'b0_0000_1111;
    end else if (dead) begin
      exp_c  = 9'b0_0000_0000;
      exp_to = 1'b1;
    end else if (init_left > 0) begin
      exp_c = 9'b0_0000_1111;
    end else begin
      waiting   = (nr_count > 0);
      not_ready = waiting ? !mem_ready
                          : (mem_chip_select && !mem_ready);
      exp_busy  = waiting;
      if (not_ready) begin
        exp_c = 9'b0_0000_0001;
        inc   = 1;
      end else if (ex_redirect) begin
        exp_c = 9'b1_1111_1100;
      end else if (lu) begin
        exp_c = 9'b0_0111_0100;
        inc   = 1;
      end else begin
        exp_c = 9'b1_1111_0000;
      end
    end
    // An enable is irrelevant where its stage is being flushed.
    mask = {1'b1, ~exp_c[3:0], 4'b1111};
    #1;
    obs_c = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, exmem_flush, memwb_flush};
    chk("ctrl", 32'(obs_c & mask), 32'(exp_c & mask));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("mem_timeout", 32'(mem_timeout), 32'(exp_to));
    chk("stall_cycles", 32'(stall_cycles), 32'(stalls));
    @(posedge clk);
    if (!rst_n) begin
      init_left = INIT_CYCLES;
      nr_count  = 0;
      dead      = 1'b0;
      stalls    = 0;
    end else if (dead) begin
      dead = 1'b1;
    end else if (init_left > 0) begin
      init_left--;
    end else begin
      if (inc == 1 && stalls < STALL_MAX) stalls++;
      if (not_ready) begin
        nr_count++;
        if (nr_count == MEM_TIMEOUT) dead = 1'b1;
      end else begin
        nr_count = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) cycle();
    rst_n = 1'b1;
    repeat (INIT_CYCLES + 1) cycle();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    init_left = INIT_CYCLES;
    nr_count  = 0;
    dead      = 1'b0;
    stalls    = 0;

    do_reset();
    chk("run_after_init", 32'(busy), 32'd0);

    ex_read_mode = 1'b1;
    ex_rd        = 5'd8;
    id_rs        = 5'd8;
    id_uses_rs   = 1'b1;
    cycle();
    ex_read_mode = 1'b0;
    cycle();
    chk("load_use_count", 32'(stall_cycles), 32'd1);
    ex_read_mode = 1'b1;
    ex_rd        = 5'd0;
    id_rs        = 5'd0;
    repeat (2) cycle();

    ex_rd       = 5'd9;
    id_rt       = 5'd9;
    id_uses_rt  = 1'b1;
    ex_redirect = 1'b1;
    cycle();
    idle();
    cycle();
    chk("redirect_no_stall", 32'(stall_cycles), 32'd1);

    mem_chip_select = 1'b1;
    mem_ready       = 1'b0;
    ex_redirect     = 1'b1;
    repeat (3) cycle();
    mem_ready = 1'b1;
    cycle();
    idle();
    cycle();
    chk("mem_wait_count", 32'(stall_cycles), 32'd4);

    do_reset();
    mem_chip_select = 1'b1;
    mem_ready       = 1'b0;
    repeat (MEM_TIMEOUT) cycle();
    chk("timeout_flag", 32'(mem_timeout), 32'd1);
    mem_ready = 1'b1;
    repeat (50) cycle();
    chk("error_holds", 32'(pc_en), 32'd0);
    idle();
    do_reset();

    ex_read_mode = 1'b1;
    ex_rd        = 5'd3;
    id_rs        = 5'd3;
    id_uses_rs   = 1'b1;
    repeat (20) cycle();
    chk("saturation", 32'(stall_cycles), 32'(STALL_MAX));
    idle();

    do_reset();
    for (int i = 0; i < 500; i++) begin
      rst_n           = ($urandom_range(99) != 0);
      id_rs           = 5'($urandom_range(3));
      id_rt           = 5'($urandom_range(3));
      id_uses_rs      = 1'($urandom);
      id_uses_rt      = 1'($urandom);
      ex_read_mode    = 1'($urandom);
      ex_rd           = 5'($urandom_range(3));
      ex_redirect     = ($urandom_range(4) == 0);
      mem_chip_select = ($urandom_range(2) == 0);
      mem_ready       = ($urandom_range(3) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
